// File: rtl/rst_sequencer_if.sv
// Request/reset bundle for the reset sequencer.
// master raises requests, slave drives the per-channel resets.
interface rst_sequencer_if #(
    parameter int NumRst = 4
);
    localparam int ChW = (NumRst > 1) ? $clog2(NumRst) : 1;

    logic [NumRst-1:0] btn_i;
    logic [NumRst-1:0] sw_req_i;
    logic [NumRst-1:0] rst_no;
    logic              all_released_o;
    logic              busy_o;
    logic [1:0]        cause_o;
    logic [ChW-1:0]    cause_ch_o;

    modport master (
        output btn_i, sw_req_i,
        input  rst_no, all_released_o, busy_o, cause_o, cause_ch_o
    );

    modport slave (
        input  btn_i, sw_req_i,
        output rst_no, all_released_o, busy_o, cause_o, cause_ch_o
    );
endinterface

// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: debounced buttons and sw pulses
// hold a channel and all higher ones, then release them in order.
module rst_sequencer #(
    parameter int NumRst         = 4,
    parameter int StretchCycles  = 16,
    parameter int GapCycles      = 8,
    parameter int DebounceCycles = 1024,
    parameter int SyncStages     = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    rst_sequencer_if.slave  bus
);
    localparam int ChW    = (NumRst > 1) ? $clog2(NumRst) : 1;
    localparam int DbW    = $clog2(DebounceCycles + 1);
    localparam int MaxCnt = (StretchCycles > GapCycles) ? StretchCycles : GapCycles;
    localparam int CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [1:0] {
        HOLD,
        STAGGER,
        RUN
    } state_e;

    logic [NumRst-1:0] sync_q [SyncStages];
    logic [NumRst-1:0] deb_q;
    logic [DbW-1:0]    db_cnt_q [NumRst];
    logic [NumRst-1:0] req;

    state_e            state_q, state_d;
    logic [ChW-1:0]    base_q, base_d;
    logic [ChW-1:0]    idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [NumRst-1:0] rst_q, rst_d;
    logic              all_q, all_d;
    logic              busy_q, busy_d;
    logic [1:0]        cause_q, cause_d;
    logic [ChW-1:0]    cause_ch_q, cause_ch_d;

    assign req = deb_q | bus.sw_req_i;

    // Button synchroniser and per-channel debounce counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
            for (int i = 0; i < NumRst; i++) db_cnt_q[i] <= '0;
            deb_q <= '0;
        end else begin
            sync_q[0] <= bus.btn_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < NumRst; i++) begin
                if (sync_q[SyncStages-1][i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbW'(DebounceCycles - 1)) begin
                    deb_q[i]    <= ~deb_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HOLD;
            base_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rst_q      <= '0;
            all_q      <= 1'b0;
            busy_q     <= 1'b1;
            cause_q    <= 2'd0;
            cause_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rst_q      <= rst_d;
            all_q      <= all_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
            cause_ch_q <= cause_ch_d;
        end
    end

    // Next state: requests re-hold from the new base, else stretch then stagger
    always_comb begin
        logic [ChW-1:0] k;
        logic [ChW-1:0] held_lo;
        logic [ChW-1:0] nb;

        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rst_d      = rst_q;
        all_d      = all_q;
        busy_d     = busy_q;
        cause_d    = cause_q;
        cause_ch_d = cause_ch_q;

        k = '0;
        for (int i = NumRst - 1; i >= 0; i--) begin
            if (req[i]) k = ChW'(i);
        end
        held_lo = (state_q == STAGGER) ? idx_q : base_q;
        nb = (state_q == RUN || k < held_lo) ? k : held_lo;

        if (|req) begin
            for (int j = 0; j < NumRst; j++) begin
                if (ChW'(j) >= nb) rst_d[j] = 1'b0;
            end
            state_d    = HOLD;
            base_d     = nb;
            cnt_d      = '0;
            all_d      = 1'b0;
            busy_d     = 1'b1;
            cause_d    = deb_q[k] ? 2'd1 : 2'd2;
            cause_ch_d = nb;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == CntW'(StretchCycles - 1)) begin
                        rst_d[base_q] = 1'b1;
                        cnt_d = '0;
                        if (base_q == ChW'(NumRst - 1)) begin
                            state_d = RUN;
                            all_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = STAGGER;
                            idx_d   = base_q + ChW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                STAGGER: begin
                    if (cnt_q == CntW'(GapCycles - 1)) begin
                        rst_d[idx_q] = 1'b1;
                        cnt_d = '0;
                        if (idx_q == ChW'(NumRst - 1)) begin
                            state_d = RUN;
                            all_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + ChW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rst_no         = rst_q;
    assign bus.all_released_o = all_q;
    assign bus.busy_o         = busy_q;
    assign bus.cause_o        = cause_q;
    assign bus.cause_ch_o     = cause_ch_q;
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset sequencer for the Guineveer FPGA top level. It replaces the hand-written per-domain reset registers and the fixed CPU-reset shift register with a single block that drives NumRst reset channels. Each channel can be requested by a debounced button or by a software pulse. Channels are released in index order after a programmable stretch, with a gap between successive releases. A reset on channel k cascades to every channel j > k, since higher indices are dependent domains: channel 0 is the SoC, channel 1 the CPU, and so on.

## Interface
- NumRst, 4: number of reset channels; must be >= 1.
- StretchCycles, 16: minimum hold time of the asserted reset before the first release; must be >= 1.
- GapCycles, 8: spacing between consecutive channel releases; must be >= 1.
- DebounceCycles, 1024: number of cycles a synchronised button level must stay stable before it is accepted; must be >= 1.
- SyncStages, 2: depth of the button synchroniser; must be >= 2.

- clk_i  in  1  clock for the whole block.
- rst_ni  in  1  asynchronous, active-low reset, typically driven from PLL lock.
- btn_i  in  NumRst  asynchronous button request per channel, active-high.
- sw_req_i  in  NumRst  synchronous single-cycle software reset request per channel.
- rst_no  out  NumRst  per-channel active-low reset outputs, registered.
- all_released_o  out  1  high when every channel is released.
- busy_o  out  1  high while any channel is held or being sequenced.
- cause_o  out  2  cause of the last sequence: 0 = power-on, 1 = button, 2 = software.
- cause_ch_o  out  $clog2(NumRst) (minimum 1)  base channel index of the last sequence.

## Operation
- Button path, per channel:
  - SyncStages-flop synchroniser, followed by a debouncer.
  - The debounce counter clears whenever the synchronised value equals the debounced state.
  - While the two differ, the counter increments each cycle. When it reaches DebounceCycles-1 and the values still differ, the debounced state flips.
  - The debounced level acts as a request for as long as it is high.
- Request vector: req = debounced_btn | sw_req_i. k is the lowest set index of req.
- Registered state: base (lowest held channel) and idx (next channel to release).
- FSM states:
  - HOLD: channels >= base are held low. The counter clears on entry and whenever req is nonzero.
    - When count == StretchCycles-1 and req == 0: go to STAGGER. rst_no[base] goes high on the same edge and idx = base+1.
    - If base+1 == NumRst, go to RUN instead.
  - STAGGER: the gap counter counts GapCycles. At the end, rst_no[idx] goes high and idx increments.
    - When the last channel is released, go to RUN.
  - RUN: all channels are released and all_released_o = 1.
- Request in any state (req != 0):
  - New base = min(k, lowest currently held channel). In RUN the lowest held channel is NumRst, so new base = k.
  - Channels >= new base are driven low on the next edge; the FSM enters HOLD with the counter cleared.
  - cause_o / cause_ch_o are updated to the new base. If the debounced button and sw_req_i are both set on channel k, cause_o = 1 (button).
- A held button keeps its request active. The stretch count starts only after the debounced release.
- Channels below base are never disturbed.

## Timing
- Reset values (rst_ni low, asynchronous):
  - rst_no = 0, all_released_o = 0, busy_o = 1, cause_o = 0, cause_ch_o = 0.
  - base = 0, FSM = HOLD, all counters and synchroniser/debounce state = 0.
- Power-on: counting starts at the first edge after rst_ni deasserts.
  - rst_no[0] rises at edge StretchCycles.
  - rst_no[i] rises at edge StretchCycles + i*GapCycles.
- all_released_o rises, and busy_o falls, on the same edge as rst_no[NumRst-1].
- sw_req_i latency: affected outputs go low on the edge that samples the pulse (visible 1 cycle later).
- Button latency: SyncStages + DebounceCycles cycles from the btn_i edge to rst_no falling, with ±1 cycle of synchroniser uncertainty.
- Release after a request: rst_no[base] rises StretchCycles edges after the last cycle with req != 0.
- rst_ni asserted mid-sequence: all outputs return to their reset values immediately, and the full power-on sequence reruns.
- Outputs are glitch-free: every output is driven directly by a flop.

## Test plan
Default parameters for all scenarios: NumRst=4, StretchCycles=16, GapCycles=8, DebounceCycles=32, SyncStages=2.
1. Power-on: deassert rst_ni -> rst_no[0..3] rise at edges 16/24/32/40; all_released_o rises at edge 40; cause_o=0, cause_ch_o=0.
2. In RUN, pulse sw_req_i=4'b0100 -> rst_no=4'b0011 on the next cycle; rst_no[2] rises 16 edges later and rst_no[3] 8 edges after that; cause_o=2, cause_ch_o=2.
3. Button glitch and hold on channel 1:
   - btn_i[1] high for 10 cycles -> no change.
   - btn_i[1] held for 200 cycles -> rst_no=4'b0001 about 34 cycles after assertion, held until 34 cycles after btn_i falls; rst_no[1] rises 16 edges later; cause_o=1, cause_ch_o=1.
4. Request mid-stagger:
   - With rst_no=4'b0011, pulse sw_req_i=4'b1000 -> base stays 2 and HOLD restarts; rst_no[2] rises at +16, rst_no[3] at +24.
   - Repeat with sw_req_i=4'b0001 -> rst_no=4'b0000.
5. Simultaneous requests: sw_req_i=4'b0110 together with debounced btn channel 1 -> base=1, cause_o=1, cause_ch_o=1.
6. Assert rst_ni during STAGGER -> all outputs reach their reset values asynchronously, with no clock edge needed; release rst_ni -> scenario 1 timing reproduces exactly.
